// File: rtl/axi_pkg.sv
// Shared response codes and FSM state encodings for the AXI slave memory.
// Byte-lane helper keeps offset width derivation in one place.
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef logic [1:0] wr_state_e;
    typedef logic [0:0] rd_state_e;

    localparam wr_state_e W_IDLE = 2'd0;
    localparam wr_state_e W_DATA = 2'd1;
    localparam wr_state_e W_WAIT = 2'd2;
    localparam wr_state_e W_RESP = 2'd3;

    localparam rd_state_e R_IDLE = 1'b0;
    localparam rd_state_e R_DATA = 1'b1;

    function automatic int ofs_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-organised storage with one byte-enabled write port
// and one combinational read port; contents are never reset.
module axi_mem_array #(
    parameter int WORDS  = 1024,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (we && wstrb[b]) begin
                mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 INCR-burst slave memory: independent write and read FSMs,
// one outstanding burst per direction, programmable B latency.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int ID_BITS   = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 3,
    parameter int MEM_WORDS = 1024,
    parameter int B_DELAY   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ID_BITS-1:0]   AWID,
    input  logic [ADDR_W-1:0]    AWADDR,
    input  logic [LEN_BITS-1:0]  AWLEN,
    input  logic [SIZE_BITS-1:0] AWSIZE,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [ID_BITS-1:0]   WID,
    input  logic [DATA_W-1:0]    WDATA,
    input  logic [DATA_W/8-1:0]  WSTRB,
    input  logic                 WLAST,
    input  logic                 WVALID,
    output logic                 WREADY,
    output logic [ID_BITS-1:0]   BID,
    output logic [1:0]           BRESP,
    output logic                 BVALID,
    input  logic                 BREADY,
    input  logic [ID_BITS-1:0]   ARID,
    input  logic [ADDR_W-1:0]    ARADDR,
    input  logic [LEN_BITS-1:0]  ARLEN,
    input  logic [SIZE_BITS-1:0] ARSIZE,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [ID_BITS-1:0]   RID,
    output logic [DATA_W-1:0]    RDATA,
    output logic [1:0]           RRESP,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFS_W  = ofs_w(DATA_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS * STRB_W);

    function automatic logic size_bad(input logic [SIZE_BITS-1:0] s);
        return 32'(s) > 32'(OFS_W);
    endfunction

    function automatic logic out_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= LIMIT;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFS_W);
    endfunction

    function automatic logic [ADDR_W-1:0] step(input logic [SIZE_BITS-1:0] s);
        return ADDR_W'(1) << s;
    endfunction

    // Holds both address channels off for one cycle after reset release
    logic rdy_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    wr_state_e             wstate;
    logic [ID_BITS-1:0]    wid_q;
    logic [ADDR_W-1:0]     waddr;
    logic [LEN_BITS-1:0]   wlen;
    logic [LEN_BITS-1:0]   wcnt;
    logic [SIZE_BITS-1:0]  wsize;
    logic                  wbad;
    logic                  wdec;
    logic                  wover;
    resp_e                 bresp_q;
    logic [3:0]            bdly;
    logic                  w_hs;
    logic                  w_oob;
    logic                  w_we;
    resp_e                 wresp_nx;

    assign w_hs  = (wstate == W_DATA) && WVALID;
    assign w_oob = out_range(waddr);
    assign w_we  = w_hs && !wbad && !w_oob;

    always_comb begin
        wresp_nx = OKAY;
        if (wbad)                    wresp_nx = SLVERR;
        else if (wdec || w_oob)      wresp_nx = DECERR;
        else if (wover || wcnt != wlen) wresp_nx = SLVERR;
    end

    assign AWREADY = rdy_en && (wstate == W_IDLE);
    assign WREADY  = (wstate == W_DATA);
    assign BVALID  = (wstate == W_RESP);
    assign BID     = wid_q;
    assign BRESP   = bresp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wstate  <= W_IDLE;
            wid_q   <= '0;
            waddr   <= '0;
            wlen    <= '0;
            wcnt    <= '0;
            wsize   <= '0;
            wbad    <= 1'b0;
            wdec    <= 1'b0;
            wover   <= 1'b0;
            bresp_q <= OKAY;
            bdly    <= '0;
        end else begin
            unique case (wstate)
                W_IDLE: if (AWVALID && rdy_en) begin
                    wid_q  <= AWID;
                    waddr  <= AWADDR;
                    wlen   <= AWLEN;
                    wsize  <= AWSIZE;
                    wcnt   <= '0;
                    wbad   <= size_bad(AWSIZE);
                    wdec   <= 1'b0;
                    wover  <= 1'b0;
                    wstate <= W_DATA;
                end
                W_DATA: if (WVALID) begin
                    waddr <= waddr + step(wsize);
                    if (w_oob) wdec <= 1'b1;
                    // saturate so an overlong burst cannot alias back to AWLEN
                    if (wcnt != wlen) wcnt <= wcnt + 1'b1;
                    else if (!WLAST)  wover <= 1'b1;
                    if (WLAST) begin
                        bresp_q <= wresp_nx;
                        bdly    <= '0;
                        wstate  <= (B_DELAY == 0) ? W_RESP : W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (bdly == 4'(B_DELAY - 1)) wstate <= W_RESP;
                    else                         bdly <= bdly + 1'b1;
                end
                W_RESP: if (BREADY) wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

    rd_state_e             rstate;
    logic [ID_BITS-1:0]    rid_q;
    logic [ADDR_W-1:0]     raddr;
    logic [LEN_BITS-1:0]   rlen;
    logic [LEN_BITS-1:0]   rcnt;
    logic [SIZE_BITS-1:0]  rsize;
    logic [DATA_W-1:0]     rdata_q;
    resp_e                 rresp_q;
    logic                  rlast_q;
    logic [ADDR_W-1:0]     ra_sel;
    logic [SIZE_BITS-1:0]  rs_sel;
    resp_e                 rbeat;
    logic [DATA_W-1:0]     mem_rd;
    logic [DATA_W-1:0]     rbeat_data;

    // Beats are prefetched into registers so R stays stable under stalls
    assign ra_sel = (rstate == R_IDLE) ? ARADDR : raddr + step(rsize);
    assign rs_sel = (rstate == R_IDLE) ? ARSIZE : rsize;

    always_comb begin
        rbeat = OKAY;
        if (size_bad(rs_sel))      rbeat = SLVERR;
        else if (out_range(ra_sel)) rbeat = DECERR;
    end

    assign rbeat_data = (rbeat == OKAY) ? mem_rd : '0;

    assign ARREADY = rdy_en && (rstate == R_IDLE);
    assign RVALID  = (rstate == R_DATA);
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rstate  <= R_IDLE;
            rid_q   <= '0;
            raddr   <= '0;
            rlen    <= '0;
            rcnt    <= '0;
            rsize   <= '0;
            rdata_q <= '0;
            rresp_q <= OKAY;
            rlast_q <= 1'b0;
        end else begin
            unique case (rstate)
                R_IDLE: if (ARVALID && rdy_en) begin
                    rstate  <= R_DATA;
                    rid_q   <= ARID;
                    raddr   <= ARADDR;
                    rlen    <= ARLEN;
                    rsize   <= ARSIZE;
                    rcnt    <= '0;
                    rdata_q <= rbeat_data;
                    rresp_q <= rbeat;
                    rlast_q <= (ARLEN == '0);
                end
                R_DATA: if (RREADY) begin
                    if (rlast_q) begin
                        rstate  <= R_IDLE;
                        rlast_q <= 1'b0;
                    end else begin
                        raddr   <= ra_sel;
                        rcnt    <= rcnt + 1'b1;
                        rdata_q <= rbeat_data;
                        rresp_q <= rbeat;
                        rlast_q <= (rcnt + 1'b1 == rlen);
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    axi_mem_array #(
        .WORDS  (MEM_WORDS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .widx  (word_idx(waddr)),
        .wdata (WDATA),
        .wstrb (WSTRB),
        .ridx  (word_idx(ra_sel)),
        .rdata (mem_rd)
    );

    logic unused_ok;
    assign unused_ok = ^WID;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomised scoreboard bench for axi_slave_mem against a byte-array
// reference model; a negedge monitor pops and checks every B and R beat.
module tb_axi_slave_mem;

    localparam int BD = 2;
    localparam int MEM_BYTES = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic [3:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, ARVALID, ARREADY, RLAST, RVALID, RREADY;

    axi_slave_mem #(.B_DELAY(BD)) dut (
        .clk(clk), .reset(reset),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    b_exp_t     exp_b[$];
    r_exp_t     exp_r[$];
    logic [7:0] ref_mem [MEM_BYTES];

    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;
    int tmo = 0;
    int tmo_seen = 0;
    bit done = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    b_exp_t      be;
    r_exp_t      re;
    int          wl_cyc = 0;
    bit          lat_pend = 1'b0;
    bit          b_stall = 1'b0;
    bit          r_stall = 1'b0;
    logic [5:0]  b_saved;
    logic [70:0] r_saved;
    int          rel_ph = 0;

    always @(negedge clk) begin
        ncyc++;
        if (!reset) begin
            chk("reset_outputs",
                128'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY,
                      RID, RDATA, RRESP, RLAST, RVALID}), 128'(0));
            rel_ph = 1;
            lat_pend = 1'b0;
            b_stall = 1'b0;
            r_stall = 1'b0;
        end else begin
            if (rel_ph == 1) begin
                chk("ready_1st_cycle_after_reset", 128'({AWREADY, ARREADY}), 128'(0));
                rel_ph = 2;
            end else if (rel_ph == 2) begin
                chk("ready_2nd_cycle_after_reset", 128'({AWREADY, ARREADY}), 128'(3));
                rel_ph = 0;
            end
            if (b_stall)
                chk("b_stable", 128'({BVALID, BID, BRESP}), 128'({1'b1, b_saved}));
            if (r_stall)
                chk("r_stable", 128'({RVALID, RID, RDATA, RRESP, RLAST}),
                    128'({1'b1, r_saved}));
            if (BVALID && lat_pend) begin
                chk("b_latency", 128'(ncyc - wl_cyc), 128'(1 + BD));
                lat_pend = 1'b0;
            end
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", 128'(1), 128'(0));
                end else begin
                    be = exp_b.pop_front();
                    chk("bid", 128'(BID), 128'(be.id));
                    chk("bresp", 128'(BRESP), 128'(be.resp));
                end
            end
            if (WVALID && WREADY && WLAST) begin
                wl_cyc = ncyc;
                lat_pend = 1'b1;
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", 128'(1), 128'(0));
                end else begin
                    re = exp_r.pop_front();
                    chk("rid", 128'(RID), 128'(re.id));
                    chk("rdata", 128'(RDATA), 128'(re.data));
                    chk("rresp", 128'(RRESP), 128'(re.resp));
                    chk("rlast", 128'(RLAST), 128'(re.last));
                end
            end
            b_stall = BVALID && !BREADY;
            b_saved = {BID, BRESP};
            r_stall = RVALID && !RREADY;
            r_saved = {RID, RDATA, RRESP, RLAST};
        end
        if (tmo != tmo_seen) begin
            chk("handshake_timeout", 128'(tmo), 128'(tmo_seen));
            tmo_seen = tmo;
        end
        if (done) begin
            chk("b_queue_empty", 128'(exp_b.size()), 128'(0));
            chk("r_queue_empty", 128'(exp_r.size()), 128'(0));
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- master side ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int ch);
        bit hs;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            case (ch)
                0: hs = AWREADY;
                1: hs = WREADY;
                2: hs = BVALID && BREADY;
                3: hs = ARREADY;
                default: hs = BVALID;
            endcase
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) tmo++;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input int nb, input logic [7:0] strb_f,
                            input logic [63:0] data_f, input int bhold);
        logic [63:0] wd [16];
        logic [7:0]  ws [16];
        logic [31:0] a;
        bit          dec, serr;
        b_exp_t      e;
        dec = 1'b0;
        serr = (size > 3);
        for (int i = 0; i < nb; i++) begin
            wd[i] = (data_f != 0) ? data_f : {$urandom, $urandom};
            ws[i] = (strb_f != 0) ? strb_f : 8'($urandom);
            a = addr + (32'(i) << size);
            if (!serr) begin
                if (a >= MEM_BYTES) dec = 1'b1;
                else for (int b = 0; b < 8; b++)
                    if (ws[i][b]) ref_mem[int'(a & ~32'd7) + b] = wd[i][b*8 +: 8];
            end
        end
        e.id = id;
        e.resp = serr ? 2'b10 : dec ? 2'b11 : (nb - 1 != int'(len)) ? 2'b10 : 2'b00;
        exp_b.push_back(e);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
        wait_hs(0);
        AWVALID = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            WID = id; WDATA = wd[i]; WSTRB = ws[i];
            WLAST = (i == nb - 1); WVALID = 1'b1;
            wait_hs(1);
            WVALID = 1'b0;
            WLAST = 1'b0;
        end
        BREADY = 1'b0;
        wait_hs(4);
        repeat (bhold) tick();
        BREADY = 1'b1;
        wait_hs(2);
        BREADY = 1'b0;
    endtask

    task automatic model_read(input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [2:0] size);
        logic [31:0] a;
        r_exp_t      r;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + (32'(i) << size);
            r.id = id;
            r.last = (i == int'(len));
            r.data = '0;
            if (size > 3) begin
                r.resp = 2'b10;
            end else if (a >= MEM_BYTES) begin
                r.resp = 2'b11;
            end else begin
                r.resp = 2'b00;
                for (int b = 0; b < 8; b++) r.data[b*8 +: 8] = ref_mem[int'(a & ~32'd7) + b];
            end
            exp_r.push_back(r);
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size);
        bit hs;
        int n;
        model_read(id, addr, len, size);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
        wait_hs(3);
        ARVALID = 1'b0;
        n = 0;
        do begin
            RREADY = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs = RVALID && RREADY && RLAST;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 300);
        RREADY = 1'b0;
        if (!hs) tmo++;
    endtask

    task automatic read_with_reset();
        int beats, n;
        model_read(4'd9, 32'h200, 4'd3, 3'd3);
        ARID = 4'd9; ARADDR = 32'h200; ARLEN = 4'd3; ARSIZE = 3'd3; ARVALID = 1'b1;
        wait_hs(3);
        ARVALID = 1'b0;
        RREADY = 1'b1;
        beats = 0;
        n = 0;
        while (beats < 2 && n < 50) begin
            @(negedge clk);
            if (RVALID && RREADY) beats++;
            @(posedge clk);
            #1;
            n++;
        end
        if (beats < 2) tmo++;
        reset = 1'b0;
        RREADY = 1'b0;
        exp_r.delete();
        tick();
        reset = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        int  op, nb, bh;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [31:0] addr;
        reset = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        for (int k = 0; k < 64; k++)
            do_write(4'(k), 32'(k * 128), 4'd15, 3'd3, 16, 8'hFF, 64'd0, 0);

        do_write(4'd3, 32'h100, 4'd3, 3'd3, 4, 8'hFF, 64'd0, 0);
        do_read(4'd3, 32'h100, 4'd3, 3'd3);

        do_write(4'd1, 32'h8, 4'd0, 3'd3, 1, 8'h0F, 64'h1122334455667788, 0);
        do_read(4'd1, 32'h8, 4'd0, 3'd3);

        do_write(4'd2, 32'h100, 4'd1, 3'd4, 2, 8'hFF, 64'd0, 0);
        do_read(4'd2, 32'h100, 4'd1, 3'd4);
        do_read(4'd2, 32'h100, 4'd1, 3'd3);

        do_read(4'd4, 32'h1FF8, 4'd1, 3'd3);

        do_write(4'd6, 32'h300, 4'd3, 3'd3, 2, 8'hFF, 64'd0, 5);
        do_read(4'd6, 32'h300, 4'd3, 3'd3);

        do_write(4'd5, 32'hFFFF_FFF8, 4'd2, 3'd3, 3, 8'hFF, 64'd0, 1);
        do_read(4'd5, 32'hFFFF_FFF8, 4'd2, 3'd3);

        read_with_reset();
        do_read(4'd10, 32'h200, 4'd3, 3'd3);

        for (int t = 0; t < 60; t++) begin
            op   = int'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            len  = 4'($urandom_range(0, 15));
            addr = 32'($urandom_range(0, 9000));
            nb   = int'(len) + 1;
            if ($urandom_range(0, 7) == 0) nb = (nb > 1) ? nb - 1 : 2;
            else if ($urandom_range(0, 7) == 0 && nb < 16) nb = nb + 1;
            bh   = int'($urandom_range(0, 2));
            if (op == 0) do_write(4'($urandom), addr, len, size, nb, 8'h00, 64'd0, bh);
            else         do_read(4'($urandom), addr, len, size);
        end

        tick();
        done = 1'b1;
        repeat (5) tick();
    end

endmodule
